// File: rtl/capture.sv
// capture: packet capture tap.
// On a rising edge of arm, the next packet seen on the sop/eop/valid stream
// is stored in a dual-port RAM (word 0 at address 0), and its length and
// status are reported.
// The host reads the stored words back through a registered read port.
//
// Stream handshake: rx_valid qualifies every beat, including rx_sop,
// rx_eop and rx_data_in. There is no backpressure. The tap only observes
// traffic, so every valid beat is consumed in the cycle it is presented.
//
// Optional feature macro: CAPTURE_MATCH_EN. When it is defined, ports
// match_data and match_mask exist, and the first word of a packet must
// match under the mask before the capture starts.
module capture #(
   parameter int ADDRWIDTH = 5,
   parameter int DATAWIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_l,
   input  logic [DATAWIDTH-1:0] rx_data_in,
   input  logic                 rx_sop,
   input  logic                 rx_eop,
   input  logic                 rx_valid,
   input  logic                 arm,
   input  logic [ADDRWIDTH-1:0] rd_addr,
   output logic [DATAWIDTH-1:0] rd_data,
   output logic                 busy,
   output logic                 done,
   output logic [ADDRWIDTH:0]   cap_len,
   output logic                 cap_ovf,
   output logic                 cap_err
`ifdef CAPTURE_MATCH_EN
   ,
   input  logic [DATAWIDTH-1:0] match_data,
   input  logic [DATAWIDTH-1:0] match_mask
`endif
);

   localparam int DEPTH = 1 << ADDRWIDTH;
   // Pointer value meaning "RAM full"; needs the extra pointer bit.
   localparam logic [ADDRWIDTH:0] DEPTH_CNT = (ADDRWIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                 state, state_nxt;
   logic [ADDRWIDTH:0]     wr_ptr, wr_ptr_nxt;
   logic [ADDRWIDTH:0]     cap_len_nxt;
   logic                   cap_ovf_nxt, cap_err_nxt;
   logic                   arm_old;
   logic                   arm_edge;
   logic                   sop_accept;
   logic                   wr_en;
   logic [ADDRWIDTH-1:0]   wr_addr;
   logic [DATAWIDTH-1:0]   mem [DEPTH];

   assign arm_edge = arm && !arm_old;

`ifdef CAPTURE_MATCH_EN
   assign sop_accept = (((rx_data_in ^ match_data) & match_mask) == '0);
`else
   assign sop_accept = 1'b1;
`endif

   assign busy = (state == S_ARMED) || (state == S_CAPTURE);
   assign done = (state == S_DONE);

   // State, pointer and status registers; reset aborts any capture in progress.
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         state   <= S_IDLE;
         wr_ptr  <= '0;
         cap_len <= '0;
         cap_ovf <= 1'b0;
         cap_err <= 1'b0;
         arm_old <= 1'b0;
      end else begin
         state   <= state_nxt;
         wr_ptr  <= wr_ptr_nxt;
         cap_len <= cap_len_nxt;
         cap_ovf <= cap_ovf_nxt;
         cap_err <= cap_err_nxt;
         arm_old <= arm;
      end
   end

   // Next-state logic, RAM write control and status updates.
   always_comb begin
      state_nxt   = state;
      wr_ptr_nxt  = wr_ptr;
      cap_len_nxt = cap_len;
      cap_ovf_nxt = cap_ovf;
      cap_err_nxt = cap_err;
      wr_en       = 1'b0;
      wr_addr     = '0;

      case (state)
         S_IDLE, S_DONE: begin
            if (arm_edge) begin
               state_nxt   = S_ARMED;
               wr_ptr_nxt  = '0;
               cap_len_nxt = '0;
               cap_ovf_nxt = 1'b0;
               cap_err_nxt = 1'b0;
            end
         end

         S_ARMED: begin
            // Only a start-of-packet beat can open a capture.
            if (rx_valid && rx_sop && sop_accept) begin
               wr_en      = 1'b1;
               wr_addr    = '0;
               wr_ptr_nxt = (ADDRWIDTH+1)'(1);
               if (rx_eop) begin
                  state_nxt   = S_DONE;
                  cap_len_nxt = (ADDRWIDTH+1)'(1);
               end else begin
                  state_nxt = S_CAPTURE;
               end
            end
         end

         S_CAPTURE: begin
            if (rx_valid) begin
               if (rx_sop) begin
                  // A new sop mid-packet restarts the capture from word 0.
                  wr_en       = 1'b1;
                  wr_addr     = '0;
                  wr_ptr_nxt  = (ADDRWIDTH+1)'(1);
                  cap_err_nxt = 1'b1;
                  cap_ovf_nxt = 1'b0;
               end else if (wr_ptr < DEPTH_CNT) begin
                  wr_en      = 1'b1;
                  wr_addr    = wr_ptr[ADDRWIDTH-1:0];
                  wr_ptr_nxt = wr_ptr + (ADDRWIDTH+1)'(1);
               end else begin
                  // RAM is full: drop the word and flag it.
                  cap_ovf_nxt = 1'b1;
               end
               if (rx_eop) begin
                  state_nxt   = S_DONE;
                  // The pointer never passes DEPTH, so the length saturates there.
                  cap_len_nxt = wr_ptr_nxt;
               end
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   // Capture RAM: one write port driven by the FSM and a registered host read port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= rx_data_in;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_capture.sv
// tb_capture: self-checking bench for capture (ADDRWIDTH=5, DATAWIDTH=16).
// The bench uses directed vector tables, hand-written corner sequences and
// randomized packets. All of them are checked against a packet-level
// reference model.
module tb_capture;

   localparam int AW    = 5;
   localparam int DW    = 16;
   localparam int DEPTH = 1 << AW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_l;
   always #5 clk = ~clk;

   logic [DW-1:0] rx_data_in;
   logic          rx_sop, rx_eop, rx_valid, arm;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          busy, done, cap_ovf, cap_err;
   logic [AW:0]   cap_len;
   logic [DW-1:0] match_data, match_mask;

   capture #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
      .clk        (clk),
      .reset_l    (reset_l),
      .rx_data_in (rx_data_in),
      .rx_sop     (rx_sop),
      .rx_eop     (rx_eop),
      .rx_valid   (rx_valid),
      .arm        (arm),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .done       (done),
      .cap_len    (cap_len),
      .cap_ovf    (cap_ovf),
      .cap_err    (cap_err)
`ifdef CAPTURE_MATCH_EN
      ,
      .match_data (match_data),
      .match_mask (match_mask)
`endif
   );

   // ---------------- scoreboard / reference model ----------------
   int n_checks = 0;
   int n_fail   = 0;

   // Words of the packet currently being captured, in arrival order.
   logic [DW-1:0] exp_q[$];
   int   m_phase;    // 0 idle, 1 waiting for sop, 2 inside packet, 3 packet stored
   logic m_err;
   logic m_arm_old;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_phase   = 0;
      m_err     = 1'b0;
      m_arm_old = 1'b0;
      exp_q.delete();
   endfunction

   function automatic void model_update(input logic a, input logic [DW-1:0] d,
                                        input logic s, input logic e, input logic v);
      logic edge_seen;
      logic hit;
      edge_seen = a && !m_arm_old;
      m_arm_old = a;
      hit = (((d ^ match_data) & match_mask) == '0);
      if (m_phase == 0 || m_phase == 3) begin
         if (edge_seen) begin
            m_phase = 1;
            m_err   = 1'b0;
            exp_q.delete();
         end
      end else if (m_phase == 1) begin
         if (v && s && hit) begin
            exp_q.delete();
            exp_q.push_back(d);
            m_phase = e ? 3 : 2;
         end
      end else begin
         if (v) begin
            if (s) begin
               exp_q.delete();
               m_err = 1'b1;
            end
            exp_q.push_back(d);
            if (e) m_phase = 3;
         end
      end
   endfunction

   // ---------------- driver ----------------
   // Drive one cycle of inputs at a negedge, let the posedge sample it,
   // then check busy and done at the following negedge.
   task automatic step(input logic a, input logic [DW-1:0] d,
                       input logic s, input logic e, input logic v);
      arm = a; rx_data_in = d; rx_sop = s; rx_eop = e; rx_valid = v;
      @(negedge clk);
      model_update(a, d, s, e, v);
      check("busy", {31'b0, busy}, {31'b0, (m_phase == 1 || m_phase == 2)});
      check("done", {31'b0, done}, {31'b0, (m_phase == 3)});
   endtask

   task automatic check_final(input string tag);
      int n;
      int exp_len;
      n = exp_q.size();
      exp_len = (n > DEPTH) ? DEPTH : n;
      check($sformatf("%s cap_len", tag), {26'b0, cap_len}, exp_len);
      check($sformatf("%s cap_ovf", tag), {31'b0, cap_ovf}, {31'b0, (n > DEPTH)});
      check($sformatf("%s cap_err", tag), {31'b0, cap_err}, {31'b0, m_err});
      for (int i = 0; i < exp_len; i++) begin
         rd_addr = AW'(i);
         step(1'b0, '0, 1'b0, 1'b0, 1'b0);
         check($sformatf("%s ram[%0d]", tag, i), {16'b0, rd_data}, {16'b0, exp_q[i]});
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          a;
      logic [DW-1:0] d;
      logic          s, e, v;
      logic          exp_busy, exp_done;
      logic [AW:0]   exp_len;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic a, input logic [DW-1:0] d, input logic s,
                               input logic e, input logic v, input logic eb,
                               input logic ed, input logic [AW:0] el);
      vec_t r;
      r.a = a; r.d = d; r.s = s; r.e = e; r.v = v;
      r.exp_busy = eb; r.exp_done = ed; r.exp_len = el;
      tbl.push_back(r);
   endfunction

   initial begin
      reset_l = 1'b0; arm = 1'b0; rx_data_in = '0; rx_sop = 1'b0; rx_eop = 1'b0;
      rx_valid = 1'b0; rd_addr = '0; match_data = '0; match_mask = '0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_l = 1'b1;
      @(negedge clk);
      check("reset busy", {31'b0, busy}, 0);
      check("reset done", {31'b0, done}, 0);
      check("reset cap_len", {26'b0, cap_len}, 0);
      check("reset cap_ovf", {31'b0, cap_ovf}, 0);
      check("reset cap_err", {31'b0, cap_err}, 0);

      // 4-word packet.
      add(1, 16'h0000, 0, 0, 0, 1, 0, 0);
      add(0, 16'h1111, 1, 0, 1, 1, 0, 0);
      add(0, 16'h2222, 0, 0, 1, 1, 0, 0);
      add(0, 16'h3333, 0, 0, 1, 1, 0, 0);
      add(0, 16'h4444, 0, 1, 1, 0, 1, 4);
      // Single-beat packet.
      add(1, 16'h0000, 0, 0, 0, 1, 0, 0);
      add(0, 16'hABCD, 1, 1, 1, 0, 1, 1);
      // Stray beats, valid gaps, and an arm edge during capture (ignored).
      add(1, 16'h0000, 0, 0, 0, 1, 0, 0);
      add(0, 16'hDEAD, 0, 0, 1, 1, 0, 0);
      add(0, 16'hDEAD, 0, 1, 1, 1, 0, 0);
      add(0, 16'h00A1, 1, 0, 1, 1, 0, 0);
      add(0, 16'h0000, 0, 0, 0, 1, 0, 0);
      add(0, 16'h0000, 0, 0, 0, 1, 0, 0);
      add(0, 16'h00A2, 0, 0, 1, 1, 0, 0);
      add(1, 16'h0000, 0, 0, 0, 1, 0, 0);
      add(0, 16'h0000, 0, 0, 0, 1, 0, 0);
      add(0, 16'h00A3, 0, 1, 1, 0, 1, 3);
      // Restart on sop mid-packet.
      add(1, 16'h0000, 0, 0, 0, 1, 0, 0);
      add(0, 16'h5000, 1, 0, 1, 1, 0, 0);
      add(0, 16'h0001, 0, 0, 1, 1, 0, 0);
      add(0, 16'h0002, 0, 0, 1, 1, 0, 0);
      add(0, 16'h5001, 1, 0, 1, 1, 0, 0);
      add(0, 16'h0007, 0, 0, 1, 1, 0, 0);
      add(0, 16'h0008, 0, 1, 1, 0, 1, 3);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].e, tbl[i].v);
         check($sformatf("vec%0d busy", i), {31'b0, busy}, {31'b0, tbl[i].exp_busy});
         check($sformatf("vec%0d done", i), {31'b0, done}, {31'b0, tbl[i].exp_done});
         check($sformatf("vec%0d cap_len", i), {26'b0, cap_len}, {26'b0, tbl[i].exp_len});
         if (tbl[i].exp_done) check_final($sformatf("vec%0d", i));
      end

      // 40-word packet overflows the 32-word RAM.
      step(1'b1, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) step(1'b0, DW'(i), (i == 0), (i == 39), 1'b1);
      check("ovf cap_len", {26'b0, cap_len}, 32);
      check("ovf flag", {31'b0, cap_ovf}, 1);
      check_final("ovf");

      // Reset in the middle of a packet.
      step(1'b1, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0C00, 1'b1, 1'b0, 1'b1);
      step(1'b0, 16'h0C01, 1'b0, 1'b0, 1'b1);
      reset_l = 1'b0; rx_data_in = 16'h0C02; rx_sop = 1'b0; rx_eop = 1'b0; rx_valid = 1'b1;
      @(negedge clk);
      reset_l = 1'b1;
      model_reset();
      check("rst busy", {31'b0, busy}, 0);
      check("rst done", {31'b0, done}, 0);
      check("rst cap_len", {26'b0, cap_len}, 0);
      step(1'b0, 16'h0C03, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0C04, 1'b1, 1'b0, 1'b1);
      step(1'b0, 16'h0C05, 1'b0, 1'b1, 1'b1);
      check("rst ignored cap_len", {26'b0, cap_len}, 0);

`ifdef CAPTURE_MATCH_EN
      // First-word match filter.
      match_data = 16'h0800; match_mask = 16'hFF00;
      step(1'b1, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0600, 1'b1, 1'b1, 1'b1);
      check("match miss busy", {31'b0, busy}, 1);
      check("match miss done", {31'b0, done}, 0);
      step(1'b0, 16'h08AA, 1'b1, 1'b1, 1'b1);
      check("match hit done", {31'b0, done}, 1);
      check_final("match");
      match_data = '0; match_mask = '0;
`endif

      // Randomized packets: stray beats, gaps, occasional restarts, overflow.
      for (int p = 0; p < 25; p++) begin
         int len;
         step(1'b0, '0, 1'b0, 1'b0, 1'b0);
         step(1'b1, '0, 1'b0, 1'b0, 1'b0);
         repeat ($urandom_range(0, 2)) step(1'b0, DW'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
         len = $urandom_range(1, 40);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, DW'($urandom), 1'b0, 1'b0, 1'b0);
            step(1'b0, DW'($urandom), (i == 0) || ($urandom_range(0, 15) == 0), (i == len - 1), 1'b1);
         end
         check_final($sformatf("rand%0d", p));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
